// File: rtl/rv32i_plic.sv
// Platform-level interrupt controller: per-source level gateway, pending/inflight
// tracking, priority arbiter and a Wishbone claim/complete register interface.
module rv32i_plic #(
   parameter int NUM_SRC = 6,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   input  logic [9:0]         wb_adr_i,
   input  logic [31:0]        wb_dat_i,
   output logic [31:0]        wb_dat_o,
   output logic               wb_ack_o,
   output logic               ext_irq_o
);

   localparam int ID_W = $clog2(NUM_SRC + 1);

   // Word offsets (byte address >> 2) of the non-priority registers.
   localparam logic [7:0] W_PENDING = 8'h20;
   localparam logic [7:0] W_ENABLE  = 8'h40;
   localparam logic [7:0] W_THRESH  = 8'h60;
   localparam logic [7:0] W_CLAIM   = 8'h61;

   logic [PRIO_W-1:0] prio [1:NUM_SRC];
   logic [NUM_SRC:1]  enable;
   logic [NUM_SRC:1]  pending;
   logic [NUM_SRC:1]  inflight;
   logic [PRIO_W-1:0] threshold;
   logic [ID_W-1:0]   best_id;
   logic [PRIO_W-1:0] best_prio;

   logic              acc;
   logic              wr;
   logic              claim_rd;
   logic              complete_wr;
   logic [7:0]        word;
   logic [31:0]       rdata;
   logic [ID_W-1:0]   arb_id;
   logic [PRIO_W-1:0] arb_prio;
   logic [NUM_SRC:1]  pending_nx;
   logic [NUM_SRC:1]  inflight_nx;
   logic              unused_bits;

   assign unused_bits = ^{wb_adr_i[1:0], best_prio};

   // A new access is accepted only while no ack is outstanding, which keeps the
   // ack a single-cycle pulse.
   assign acc         = wb_cyc_i && wb_stb_i && !wb_ack_o;
   assign wr          = acc && wb_we_i;
   assign word        = wb_adr_i[9:2];
   assign claim_rd    = acc && !wb_we_i && (word == W_CLAIM) && (best_id != '0);
   assign complete_wr = wr && (word == W_CLAIM);

   // Ascending scan with a strict compare keeps the lowest ID on priority ties.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      arb_id   = '0;
      arb_prio = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > arb_prio)) begin
            arb_id   = ID_W'(i);
            arb_prio = prio[i];
         end
      end
   end

   // Gateway: a claim beats a same-cycle set; the old inflight value gates the
   // set, so a completed source re-pends one edge after the complete.
   always_comb begin
      pending_nx  = pending;
      inflight_nx = inflight;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (claim_rd && (best_id == ID_W'(i))) begin
            pending_nx[i]  = 1'b0;
            inflight_nx[i] = 1'b1;
         end else begin
            if (irq_i[i-1] && !inflight[i])
               pending_nx[i] = 1'b1;
            if (complete_wr && (wb_dat_i == 32'(i)) && inflight[i])
               inflight_nx[i] = 1'b0;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         if (word == 8'(i))
            rdata = 32'(prio[i]);
      end
      case (word)
         W_PENDING: rdata = 32'({pending, 1'b0});
         W_ENABLE:  rdata = 32'({enable, 1'b0});
         W_THRESH:  rdata = 32'(threshold);
         W_CLAIM:   rdata = 32'(best_id);
         default:   ;
      endcase
   end

   // NOTE: the priority array is small and fully reset so software always reads
   // a defined value; sequential state is assigned with <= only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= NUM_SRC; i++)
            prio[i] <= '0;
         enable    <= '0;
         threshold <= '0;
         pending   <= '0;
         inflight  <= '0;
         best_id   <= '0;
         best_prio <= '0;
         ext_irq_o <= 1'b0;
         wb_ack_o  <= 1'b0;
         wb_dat_o  <= '0;
      end else begin
         pending   <= pending_nx;
         inflight  <= inflight_nx;
         best_id   <= arb_id;
         best_prio <= arb_prio;
         ext_irq_o <= (arb_id != '0);
         wb_ack_o  <= acc;
         wb_dat_o  <= (acc && !wb_we_i) ? rdata : '0;
         if (wr) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
               if (word == 8'(i))
                  prio[i] <= wb_dat_i[PRIO_W-1:0];
            end
            if (word == W_ENABLE)
               enable <= wb_dat_i[NUM_SRC:1];
            if (word == W_THRESH)
               threshold <= wb_dat_i[PRIO_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_rv32i_plic.sv
// Directed bench for rv32i_plic: interrupt latency, claim/complete, arbitration,
// threshold gating, bad completes and reset during a bus access.
module tb_rv32i_plic;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  irq_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [9:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        ext_irq_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd;

   rv32i_plic #(.NUM_SRC(6), .PRIO_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_i     (irq_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_we_i   (wb_we_i),
      .wb_adr_i  (wb_adr_i),
      .wb_dat_i  (wb_dat_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .ext_irq_o (ext_irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns 1ns after the acking edge.
   task automatic wb_rd(input logic [9:0] a, output logic [31:0] d);
      logic got;
      got = 1'b0;
      d   = '0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge clk); #1;
         if (wb_ack_o) begin
            got = 1'b1;
            d   = wb_dat_o;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      check($sformatf("rd_ack_%h", a), 32'(got), 32'd1);
   endtask

   task automatic wb_wr(input logic [9:0] a, input logic [31:0] d);
      logic got;
      got = 1'b0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge clk); #1;
         if (wb_ack_o) got = 1'b1;
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      check($sformatf("wr_ack_%h", a), 32'(got), 32'd1);
   endtask

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; irq_i = '0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0;
      #12;
      check("rst_ack", 32'(wb_ack_o), 32'd0);
      check("rst_ext", 32'(ext_irq_o), 32'd0);
      check("rst_dat", wb_dat_o, 32'd0);
      @(negedge clk); reset = 1'b0;

      // Basic interrupt on source 6.
      wb_wr(10'h018, 32'd1);
      wb_wr(10'h100, 32'h40);
      wb_wr(10'h180, 32'd0);
      @(negedge clk); irq_i = 6'b100000;
      edges(1);
      check("lat_edge1", 32'(ext_irq_o), 32'd0);
      edges(1);
      check("lat_edge2", 32'(ext_irq_o), 32'd1);
      wb_rd(10'h080, rd);
      check("pend_40", rd, 32'h40);
      wb_rd(10'h184, rd);
      check("claim_6", rd, 32'd6);
      check("ext_at_claim_ack", 32'(ext_irq_o), 32'd1);
      edges(1);
      check("ext_after_claim", 32'(ext_irq_o), 32'd0);
      wb_rd(10'h080, rd);
      check("pend_inflight_0", rd, 32'h0);

      // Complete with the level still high re-pends two edges later.
      wb_wr(10'h184, 32'd6);
      check("repend_e0", 32'(ext_irq_o), 32'd0);
      edges(1);
      check("repend_e1", 32'(ext_irq_o), 32'd0);
      edges(1);
      check("repend_e2", 32'(ext_irq_o), 32'd1);
      wb_rd(10'h184, rd);
      check("claim_6_again", rd, 32'd6);
      @(negedge clk); irq_i = '0;
      wb_wr(10'h184, 32'd6);
      edges(3);
      check("low_complete_ext", 32'(ext_irq_o), 32'd0);
      wb_rd(10'h080, rd);
      check("low_complete_pend", rd, 32'h0);

      // Priority and lowest-ID tie-break among sources 1, 4, 5.
      wb_wr(10'h004, 32'd2);
      wb_wr(10'h010, 32'd5);
      wb_wr(10'h014, 32'd5);
      wb_wr(10'h100, 32'h32);
      @(negedge clk); irq_i = 6'b011001;
      @(negedge clk); irq_i = '0;
      edges(2);
      wb_rd(10'h080, rd);
      check("pend_145", rd, 32'h32);
      check("ext_145", 32'(ext_irq_o), 32'd1);
      wb_rd(10'h184, rd);
      check("claim_4", rd, 32'd4);
      wb_wr(10'h184, 32'd4);
      wb_rd(10'h184, rd);
      check("claim_5", rd, 32'd5);
      wb_wr(10'h184, 32'd5);
      wb_rd(10'h184, rd);
      check("claim_1", rd, 32'd1);
      wb_wr(10'h184, 32'd1);
      wb_rd(10'h184, rd);
      check("claim_none", rd, 32'd0);
      edges(2);
      check("ext_idle", 32'(ext_irq_o), 32'd0);

      // Threshold and enable gating on source 2.
      wb_wr(10'h008, 32'd3);
      wb_wr(10'h180, 32'd3);
      wb_wr(10'h100, 32'h04);
      @(negedge clk); irq_i = 6'b000010;
      edges(3);
      check("thr_block", 32'(ext_irq_o), 32'd0);
      wb_rd(10'h080, rd);
      check("thr_pend", rd, 32'h04);
      wb_wr(10'h180, 32'd2);
      check("thr2_e0", 32'(ext_irq_o), 32'd0);
      edges(1);
      check("thr2_e1", 32'(ext_irq_o), 32'd1);
      wb_wr(10'h100, 32'h00);
      check("en_off_e0", 32'(ext_irq_o), 32'd1);
      edges(1);
      check("en_off_e1", 32'(ext_irq_o), 32'd0);
      wb_wr(10'h180, 32'd0);
      wb_wr(10'h008, 32'd0);
      wb_wr(10'h100, 32'h04);
      edges(3);
      check("prio0_ext", 32'(ext_irq_o), 32'd0);
      wb_rd(10'h184, rd);
      check("prio0_claim", rd, 32'd0);
      @(negedge clk); irq_i = '0;

      // Bad completes leave source 2 inflight.
      wb_wr(10'h008, 32'd1);
      edges(2);
      check("src2_ext", 32'(ext_irq_o), 32'd1);
      wb_rd(10'h184, rd);
      check("claim_2", rd, 32'd2);
      wb_wr(10'h184, 32'd0);
      wb_wr(10'h184, 32'd7);
      wb_wr(10'h184, 32'd3);
      @(negedge clk); irq_i = 6'b000010;
      edges(3);
      wb_rd(10'h080, rd);
      check("bad_cmp_pend", rd, 32'h0);
      check("bad_cmp_ext", 32'(ext_irq_o), 32'd0);
      wb_wr(10'h184, 32'd2);
      edges(3);
      wb_rd(10'h080, rd);
      check("good_cmp_pend", rd, 32'h04);
      check("good_cmp_ext", 32'(ext_irq_o), 32'd1);
      wb_rd(10'h0C0, rd);
      check("reserved_0c0", rd, 32'h0);
      wb_rd(10'h000, rd);
      check("reserved_000", rd, 32'h0);
      wb_wr(10'h080, 32'hFFFF_FFFF);
      wb_rd(10'h080, rd);
      check("pend_wr_ignored", rd, 32'h04);
      wb_wr(10'h00C, 32'hFFFF_FFFF);
      wb_rd(10'h00C, rd);
      check("prio3_width", rd, 32'd7);
      wb_rd(10'h100, rd);
      check("enable_rd", rd, 32'h04);

      // Reset while source 3 is inflight and a read is waiting for its ack.
      wb_wr(10'h100, 32'h0C);
      @(negedge clk); irq_i = 6'b000110;
      edges(3);
      wb_rd(10'h184, rd);
      check("claim_3", rd, 32'd3);
      edges(2);
      check("pre_rst_ext", 32'(ext_irq_o), 32'd1);
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 10'h180;
      #2 reset = 1'b1;
      #1;
      check("midrst_ack", 32'(wb_ack_o), 32'd0);
      check("midrst_ext", 32'(ext_irq_o), 32'd0);
      check("midrst_dat", wb_dat_o, 32'd0);
      edges(2);
      check("midrst_hold_ack", 32'(wb_ack_o), 32'd0);
      @(negedge clk);
      reset = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; irq_i = '0;
      wb_rd(10'h184, rd);
      check("post_rst_claim", rd, 32'd0);
      for (int i = 1; i <= 6; i++) begin
         wb_rd(10'(4 * i), rd);
         check($sformatf("post_rst_prio%0d", i), rd, 32'd0);
      end
      wb_rd(10'h080, rd);
      check("post_rst_pend", rd, 32'h0);
      wb_rd(10'h100, rd);
      check("post_rst_en", rd, 32'h0);
      wb_rd(10'h180, rd);
      check("post_rst_thr", rd, 32'h0);
      check("post_rst_ext", 32'(ext_irq_o), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
